// File: rtl/lns_pkg.sv
// Shared LNS types and constants, plus the phi table generators evaluated at elaboration.
// The generators use integer-only fixed-point exp2/log2 so that every tool folds them to constants.
package lns_pkg;

    typedef logic signed [10:0] lns_t;

    localparam int   FRAC_W     = 5;
    localparam lns_t LNS_MAX    = 11'sh3FF;
    localparam lns_t LNS_MIN    = 11'sh400;
    localparam int   ZTHR_DEF   = 512;
    localparam int   ADDR_W_DEF = 6;

    localparam logic [63:0] Q30_ONE = 64'd1 << 30;
    localparam int          LOG_P   = 16;

    // 2^(-a/32) in Q30; the multipliers are 2^(-1/32), 2^(-2/32), ... 2^(-16/32)
    function automatic logic [63:0] exp2_neg_q30(input int a);
        logic [63:0] y;
        y = Q30_ONE;
        if (a[0]) y = (y * 64'd1050733751) >> 30;
        if (a[1]) y = (y * 64'd1028218693) >> 30;
        if (a[2]) y = (y * 64'd984625594) >> 30;
        if (a[3]) y = (y * 64'd902905651) >> 30;
        if (a[4]) y = (y * 64'd759250125) >> 30;
        return y >> (a >> FRAC_W);
    endfunction

    // log2 of a Q30 value by normalise-and-square, LOG_P fraction bits
    function automatic int log2_q30(input logic [63:0] v_in);
        logic [63:0] v;
        int          res;
        v   = v_in;
        res = 0;
        for (int k = 0; k < 40; k++) begin
            if (v >= (Q30_ONE << 1)) begin
                v   = v >> 1;
                res = res + (1 << LOG_P);
            end
            if (v != 64'd0 && v < Q30_ONE) begin
                v   = v << 1;
                res = res - (1 << LOG_P);
            end
        end
        for (int i = LOG_P - 1; i >= 0; i--) begin
            v = (v * v) >> 30;
            if (v >= (Q30_ONE << 1)) begin
                v   = v >> 1;
                res = res + (1 << i);
            end
        end
        return res;
    endfunction

    function automatic int q_round(input int x);
        return (x + (1 << (LOG_P - FRAC_W - 1))) >>> (LOG_P - FRAC_W);
    endfunction

    // sb(a) = log2(1 + 2^a) = a + log2(1 + 2^-a)
    function automatic lns_t lns_sb_entry(input int a);
        int v;
        v = a + q_round(log2_q30(Q30_ONE + exp2_neg_q30(a)));
        return lns_t'(v);
    endfunction

    // db(-a) = log2(1 - 2^-a); the pole at a=0 is pinned to LNS_MIN
    function automatic lns_t lns_db_entry(input int a);
        int v;
        if (a == 0) begin
            v = int'(LNS_MIN);
        end else begin
            v = q_round(log2_q30(Q30_ONE - exp2_neg_q30(a)));
            if (v < int'(LNS_MIN)) v = int'(LNS_MIN);
        end
        return lns_t'(v);
    endfunction

endpackage

// File: rtl/lns_phi_rom.sv
// Synchronous dual-read sb/db table: e0 = entry idx, e1 = entry idx+1 (clamped at the last entry).
// One-cycle read latency; en freezes the outputs while the pipeline is stalled.
module lns_phi_rom
    import lns_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] idx,
    input  logic              sel_sb,
    output lns_t              e0,
    output lns_t              e1
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int STEP_SH = 9 - ADDR_W;

    lns_t sb_tab [DEPTH];
    lns_t db_tab [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        localparam lns_t SB_K = lns_sb_entry(k << STEP_SH);
        localparam lns_t DB_K = lns_db_entry(k << STEP_SH);
        assign sb_tab[k] = SB_K;
        assign db_tab[k] = DB_K;
    end

    logic [ADDR_W-1:0] idx1;
    lns_t              e0_d, e1_d, e0_q, e1_q;

    always_comb begin
        idx1 = (idx == ADDR_W'(DEPTH - 1)) ? idx : idx + 1'b1;
        e0_d = e0_q;
        e1_d = e1_q;
        if (en) begin
            e0_d = sel_sb ? sb_tab[idx]  : db_tab[idx];
            e1_d = sel_sb ? sb_tab[idx1] : db_tab[idx1];
        end
    end

    always_ff @(posedge clk) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign e0 = e0_q;
    assign e1 = e1_q;

endmodule

// File: rtl/lns_gauss_log_unit.sv
// LNS add/sub back end r = w + phi(z): classify, table read, interpolate/saturate; 3 cycles, 1/clk, stall-in-place.
// LNS_INTERP_EN adds linear interpolation between adjacent table entries; otherwise phi is the lower entry.
module lns_gauss_log_unit
    import lns_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ZTHR   = ZTHR_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [10:0] w,
    input  logic signed [10:0] z,
    input  logic               z_s,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [10:0] r,
    output logic               r_zero,
    output logic               r_ovf
);

    localparam int FR_W = 9 - ADDR_W;

    logic               adv;
    logic [10:0]        a_in;
    logic               big_in, dz0_in;

    logic               s1_vld_d, s1_vld_q, s1_sb_d, s1_sb_q, s1_big_d, s1_big_q, s1_dz0_d, s1_dz0_q;
    logic signed [10:0] s1_w_d, s1_w_q;
    logic [10:0]        s1_a_d, s1_a_q;

    logic               s2_vld_d, s2_vld_q, s2_sb_d, s2_sb_q, s2_big_d, s2_big_q, s2_dz0_d, s2_dz0_q;
    logic signed [10:0] s2_w_d, s2_w_q;
    logic [10:0]        s2_a_d, s2_a_q;

    logic               out_vld_d, out_vld_q, r_zero_d, r_zero_q, r_ovf_d, r_ovf_q;
    logic signed [10:0] r_d, r_q;

    lns_t               e0, e1;
    logic signed [11:0] phi_lut, phi, sum;

    lns_phi_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk    (clk),
        .en     (adv),
        .idx    (s1_a_q[8:FR_W]),
        .sel_sb (s1_sb_q),
        .e0     (e0),
        .e1     (e1)
    );

`ifdef LNS_INTERP_EN
    logic [FR_W-1:0]    frac;
    logic signed [11:0] diff;
    logic signed [15:0] prod;

    // arithmetic shift of the signed product floors toward -inf
    always_comb begin
        frac    = s2_a_q[FR_W-1:0];
        diff    = 12'(e1) - 12'(e0);
        prod    = 16'(diff) * 16'($signed({1'b0, frac}));
        phi_lut = 12'(e0) + 12'(prod >>> FR_W);
    end
`else
    logic unused_e1;
    assign unused_e1 = ^e1;
    assign phi_lut   = 12'(e0);
`endif

    assign adv       = !out_vld_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign r         = r_q;
    assign r_zero    = r_zero_q;
    assign r_ovf     = r_ovf_q;

    always_comb begin
        a_in   = z[10] ? (~z + 11'd1) : z;
        big_in = (a_in >= 11'(ZTHR));
        dz0_in = !z_s && (z == '0);
    end

    always_comb begin
        phi = s2_big_q ? (s2_sb_q ? $signed({1'b0, s2_a_q}) : 12'sd0) : phi_lut;
        sum = 12'(s2_w_q) + phi;
    end

    always_comb begin
        s1_vld_d = s1_vld_q; s1_w_d = s1_w_q; s1_a_d = s1_a_q;
        s1_sb_d  = s1_sb_q;  s1_big_d = s1_big_q; s1_dz0_d = s1_dz0_q;
        s2_vld_d = s2_vld_q; s2_w_d = s2_w_q; s2_a_d = s2_a_q;
        s2_sb_d  = s2_sb_q;  s2_big_d = s2_big_q; s2_dz0_d = s2_dz0_q;
        out_vld_d = out_vld_q; r_d = r_q; r_zero_d = r_zero_q; r_ovf_d = r_ovf_q;
        if (adv) begin
            s1_vld_d = in_valid; s1_w_d = w; s1_a_d = a_in;
            s1_sb_d  = z_s;      s1_big_d = big_in; s1_dz0_d = dz0_in;
            s2_vld_d = s1_vld_q; s2_w_d = s1_w_q; s2_a_d = s1_a_q;
            s2_sb_d  = s1_sb_q;  s2_big_d = s1_big_q; s2_dz0_d = s1_dz0_q;
            out_vld_d = s2_vld_q;
            r_zero_d  = 1'b0;
            r_ovf_d   = 1'b0;
            // exact cancellation wins over the pole entry and any saturation
            if (s2_dz0_q) begin
                r_d      = LNS_MIN;
                r_zero_d = 1'b1;
            end else if (sum > 12'sd1023) begin
                r_d     = LNS_MAX;
                r_ovf_d = 1'b1;
            end else if (sum < -12'sd1024) begin
                r_d     = LNS_MIN;
                r_ovf_d = 1'b1;
            end else begin
                r_d = sum[10:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1_vld_q <= 1'b0; s1_w_q <= '0; s1_a_q <= '0;
            s1_sb_q  <= 1'b0; s1_big_q <= 1'b0; s1_dz0_q <= 1'b0;
            s2_vld_q <= 1'b0; s2_w_q <= '0; s2_a_q <= '0;
            s2_sb_q  <= 1'b0; s2_big_q <= 1'b0; s2_dz0_q <= 1'b0;
            out_vld_q <= 1'b0; r_q <= '0; r_zero_q <= 1'b0; r_ovf_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d; s1_w_q <= s1_w_d; s1_a_q <= s1_a_d;
            s1_sb_q  <= s1_sb_d;  s1_big_q <= s1_big_d; s1_dz0_q <= s1_dz0_d;
            s2_vld_q <= s2_vld_d; s2_w_q <= s2_w_d; s2_a_q <= s2_a_d;
            s2_sb_q  <= s2_sb_d;  s2_big_q <= s2_big_d; s2_dz0_q <= s2_dz0_d;
            out_vld_q <= out_vld_d; r_q <= r_d; r_zero_q <= r_zero_d; r_ovf_q <= r_ovf_d;
        end
    end

endmodule
